fetch_sequencer: RTL and testbench

Sequences instruction fetch for the RISC-V pipeline. Owns the program counter and drives a request/ack handshake to instruction memory. Presents each fetched 32-bit word to the decode stage through a valid/ready handshake. Supports free-run and single-step operation, branch/jump redirect, halt on ECALL/EBREAK, and a memory-timeout fault.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_timeout_ctr.sv | 23 ++
 rtl/fetch_sequencer.sv | 95 +++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the fetch sequencer
package rv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [6:0]  OP_SYSTEM    = 7'b1110011;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] PC_INCR      = 32'd4;

  function automatic logic is_halt_instr(input logic [31:0] word);
    return (word[6:0] == OP_SYSTEM) && ((word == INSTR_ECALL) || (word == INSTR_EBREAK));
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - imem, decode and redirect handshake bundle
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    input  imem_rdata, imem_ack, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    output imem_rdata, imem_ack, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - counts unacknowledged request cycles, flags the last allowed one
module fetch_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  // expire marks the LIMIT-th waiting cycle so the FSM leaves REQ on that edge
  assign expire = enable && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - owns the PC, fetches from imem and hands words to decode
module fetch_sequencer
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  fetch_sequencer_if.master bus,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);
  fetch_state_t state, state_d;
  logic [31:0]  pc, pc_d, addr_q, instr_q, ipc_q, redir_pc;
  logic         squash, xfer, redir, ack_ok, tmo_en, tmo_exp;

  assign xfer     = (state == ST_VALID) && bus.instr_ready;
  assign redir    = bus.redirect_valid && (state != ST_HALT);
  assign redir_pc = bus.redirect_pc & ~32'h3;
  assign ack_ok   = (state == ST_REQ) && bus.imem_ack && !squash && !redir;
  assign pc_d     = redir ? redir_pc : (xfer ? pc + PC_INCR : pc);
  assign tmo_en   = (state == ST_REQ) && !bus.imem_ack;

  fetch_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (!tmo_en),
    .enable (tmo_en),
    .expire (tmo_exp)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (!redir && (run || step)) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.imem_ack) state_d = ack_ok ? ST_VALID : ST_REQ;
        else if (tmo_exp) state_d = ST_HALT;
      end
      ST_VALID: begin
        if (xfer)       state_d = is_halt_instr(instr_q) ? ST_HALT : (run ? ST_REQ : ST_IDLE);
        else if (redir) state_d = run ? ST_REQ : ST_IDLE;
      end
      default:  state_d = ST_HALT;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state == ST_REQ);
    bus.instr_valid = (state == ST_VALID);
    halted          = (state == ST_HALT);
  end

  assign bus.imem_addr = addr_q;
  assign bus.instr_out = instr_q;
  assign bus.instr_pc  = ipc_q;

  // addr_q freezes while a request is outstanding, so a redirect only moves pc
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      instr_q     <= '0;
      ipc_q       <= '0;
      squash      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= pc_d;
      if (!((state == ST_REQ) && !bus.imem_ack && (state_d == ST_REQ))) addr_q <= pc_d;
      if (ack_ok) begin
        instr_q <= bus.imem_rdata;
        ipc_q   <= addr_q;
      end
      if (state == ST_REQ) begin
        if (bus.imem_ack) squash <= 1'b0;
        else if (redir)   squash <= 1'b1;
      end else begin
        squash <= 1'b0;
      end
      if (tmo_exp) fault <= 1'b1;
      if (xfer) fetch_count <= fetch_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed plus randomized bench with a transaction-level model
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        halted, fault;
  logic [31:0] fetch_count;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .step       (step),
    .bus        (bus),
    .halted     (halted),
    .fault      (fault),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // memory responder configuration
  int          lat_lo = 0, lat_hi = 0, lat_left = 0;
  bit          withhold = 0, use_force = 0, pend = 0;
  logic [31:0] force_val = 32'h13, pend_addr = '0, last_req_addr = '0;
  int          req_starts = 0;

  // reference model: architectural pc, retired count, halt/fault status
  logic [31:0] m_pc = RESET_PC;
  int unsigned m_cnt = 0;
  bit          m_halt = 0, m_fault = 0;
  int          m_wait = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (use_force) return force_val;
    return ((a * 32'h9E37_79B1) & 32'hFFFF_FF80) | 32'h13;
  endfunction

  task automatic tick();
    bit was_halt, x;
    if (reset_n) begin
      was_halt = m_halt;
      if (!was_halt) begin
        x = bus.instr_valid && bus.instr_ready;
        if (x) begin
          m_cnt++;
          if (mem_word(m_pc) == 32'h0000_0073 || mem_word(m_pc) == 32'h0010_0073) m_halt = 1;
          m_pc = m_pc + 32'd4;
        end
        if (bus.redirect_valid) m_pc = bus.redirect_pc & ~32'h3;
        if (bus.imem_req && !bus.imem_ack) m_wait++;
        else m_wait = 0;
        if (m_wait == TIMEOUT) begin
          m_halt  = 1;
          m_fault = 1;
        end
      end
    end
    @(posedge clock);
    #1;
    if (reset_n && bus.imem_req) begin
      if (!pend) begin
        pend = 1;
        pend_addr = bus.imem_addr;
        last_req_addr = bus.imem_addr;
        req_starts++;
        lat_left = $urandom_range(lat_hi, lat_lo);
      end else begin
        chk("addr_stable", bus.imem_addr, pend_addr);
      end
      if (!withhold && lat_left == 0) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        pend = 0;
      end else begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        lat_left--;
      end
    end else begin
      pend = 0;
      bus.imem_ack = 1'b0;
    end
    @(negedge clock);
    chk("count", fetch_count, m_cnt);
    chk("halted", halted, m_halt);
    chk("fault", fault, m_fault);
    if (bus.instr_valid) begin
      chk("instr_pc", bus.instr_pc, m_pc);
      chk("instr_out", bus.instr_out, mem_word(m_pc));
    end
    if (m_halt) chk("req_in_halt", bus.imem_req, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    withhold = 0;
    pend = 0;
    req_starts = 0;
    repeat (2) @(negedge clock);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_out", bus.instr_out, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_count", fetch_count, 32'h0);
    m_pc = RESET_PC;
    m_cnt = 0;
    m_halt = 0;
    m_fault = 0;
    m_wait = 0;
    reset_n = 1'b1;
  endtask

  int vcount, nreq;
  bit got;

  initial begin
    // free-run, zero-latency memory, decode always ready
    do_reset();
    use_force = 1; force_val = 32'h0000_0013; lat_lo = 0; lat_hi = 0;
    run = 1; bus.instr_ready = 1;
    vcount = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (bus.instr_valid) vcount++;
    end
    chk("t1_valid_pulses", vcount, 8);
    chk("t1_count", fetch_count, 8);
    chk("t1_next_addr", bus.imem_addr, 32'd32);

    // single step
    do_reset();
    step = 1;
    tick();
    step = 0;
    nreq = bus.imem_req ? 1 : 0;
    tick();
    chk("t2_valid", bus.instr_valid, 1'b1);
    tick();
    chk("t2_hold", bus.instr_valid, 1'b1);
    bus.instr_ready = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (bus.imem_req) nreq++;
      tick();
    end
    chk("t2_req_total", nreq, 1);
    chk("t2_idle_valid", bus.instr_valid, 1'b0);
    chk("t2_pc", bus.imem_addr, 32'd4);

    // redirect during a slow request
    do_reset();
    use_force = 0; lat_lo = 3; lat_hi = 3;
    run = 1; bus.instr_ready = 1;
    tick();
    bus.redirect_valid = 1; bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect_valid = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (bus.instr_valid) got = 1;
      else tick();
    end
    chk("t3_reached_valid", got, 1'b1);
    chk("t3_req_starts", req_starts, 2);
    chk("t3_req_addr", last_req_addr, 32'h100);
    chk("t3_instr_pc", bus.instr_pc, 32'h100);
    chk("t3_count_before", fetch_count, 0);
    tick();
    chk("t3_count_after", fetch_count, 1);

    // ECALL halts; run, step and redirect are ignored afterwards
    do_reset();
    use_force = 1; force_val = 32'h0000_0073; lat_lo = 0; lat_hi = 0;
    run = 1; bus.instr_ready = 1;
    repeat (3) tick();
    chk("t4_halted", halted, 1'b1);
    chk("t4_count", fetch_count, 1);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step = i[0];
      bus.redirect_valid = (i == 4);
      tick();
      if (bus.imem_req) nreq++;
    end
    step = 0; bus.redirect_valid = 0;
    chk("t4_no_req", nreq, 0);
    chk("t4_fault", fault, 1'b0);

    // timeout fault
    do_reset();
    use_force = 0; withhold = 1; run = 1;
    tick();
    nreq = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      if (bus.imem_req) nreq++;
      tick();
    end
    chk("t5_req_cycles", nreq, TIMEOUT);
    chk("t5_fault", fault, 1'b1);
    chk("t5_halted", halted, 1'b1);
    do_reset();

    // decode stall then redirect
    lat_lo = 0; lat_hi = 0; run = 1; bus.instr_ready = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = bus.instr_valid;
    end
    chk("t6_reached_valid", got, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_stall_pc", bus.instr_pc, 32'h0);
      chk("t6_stall_out", bus.instr_out, mem_word(32'h0));
    end
    bus.redirect_valid = 1; bus.redirect_pc = 32'h0000_0040;
    tick();
    bus.redirect_valid = 0;
    chk("t6_drop_valid", bus.instr_valid, 1'b0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = bus.instr_valid;
    end
    chk("t6_target_pc", bus.instr_pc, 32'h40);
    chk("t6_count", fetch_count, 0);

    // randomized run against the model
    do_reset();
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom % 8) != 0;
      step = ($urandom % 4) == 0;
      bus.instr_ready = ($urandom % 3) != 0;
      bus.redirect_valid = ($urandom % 16) == 0;
      bus.redirect_pc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
